// File: rtl/gpio_pkg.sv
// Shared constants for the 32-bit GPIO controller: register word offsets,
// field width and the pull-mode / pad-strength encodings.
package gpio_pkg;

  localparam int GPIO_W = 32;

  // Word index, i.e. bus_addr[5:2]
  localparam logic [3:0] REG_DO       = 4'h0;
  localparam logic [3:0] REG_DO_SET   = 4'h1;
  localparam logic [3:0] REG_DO_CLR   = 4'h2;
  localparam logic [3:0] REG_DIR      = 4'h3;
  localparam logic [3:0] REG_AFC      = 4'h4;
  localparam logic [3:0] REG_PIN      = 4'h5;
  localparam logic [3:0] REG_RISE_EN  = 4'h6;
  localparam logic [3:0] REG_FALL_EN  = 4'h7;
  localparam logic [3:0] REG_IRQ_STAT = 4'h8;
  localparam logic [3:0] REG_PM_LO    = 4'h9;
  localparam logic [3:0] REG_PM_HI    = 4'hA;
  localparam logic [3:0] REG_PS_LO    = 4'hB;
  localparam logic [3:0] REG_PS_HI    = 4'hC;

  localparam logic [1:0] PULL_NONE  = 2'b00;
  localparam logic [1:0] PULL_UP    = 2'b01;
  localparam logic [1:0] PULL_DOWN  = 2'b10;
  localparam logic [1:0] PULL_KEEP  = 2'b11;

  localparam logic [1:0] DRIVE_2MA  = 2'b00;
  localparam logic [1:0] DRIVE_4MA  = 2'b01;
  localparam logic [1:0] DRIVE_8MA  = 2'b10;
  localparam logic [1:0] DRIVE_12MA = 2'b11;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage synchroniser for asynchronous pad readback plus a history flop
// and per-bit rising/falling edge detection.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH  = GPIO_W,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Pins owned by an alternate function never raise events
  assign sync_out = sync_q[STAGES-1];
  assign rise     =  sync_out & ~prev_q & rise_en & ~mask;
  assign fall     = ~sync_out &  prev_q & fall_en & ~mask;

endmodule

// File: rtl/gpio_ctrl32.sv
// Register-mapped 32-bit GPIO controller driving the AFIO32 pad mux, with
// synchronised pin readback and edge-triggered level interrupt.
module gpio_ctrl32
  import gpio_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] DIR_RST     = 32'h0,
  parameter logic [31:0] AFC_RST     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [5:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic [31:0] GPIO_DO,
  output logic [31:0] GPIO_DI,
  output logic [31:0] GPIO_DIR,
  output logic [31:0] GPIO_AFC,
  output logic [63:0] GPIO_PM,
  output logic [63:0] GPIO_PS,
  output logic        irq
);

  logic [GPIO_W-1:0] do_q, dir_q, afc_q, rise_en_q, fall_en_q, irq_stat_q;
  logic [63:0]       pm_q, ps_q;
  logic [GPIO_W-1:0] pin_sync, rise, fall, w1c_mask, rd_mux;
  logic [3:0]        reg_idx;
  logic              wr_en, rd_en;
  logic              unused_addr_bits;

  assign reg_idx          = bus_addr[5:2];
  assign unused_addr_bits = ^bus_addr[1:0];
  assign wr_en            = bus_req &  bus_we;
  assign rd_en            = bus_req & ~bus_we;

  gpio_sync_edge #(
    .WIDTH  (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (GPIO_DO),
    .rise_en  (rise_en_q),
    .fall_en  (fall_en_q),
    .mask     (afc_q),
    .sync_out (pin_sync),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_q      <= '0;
      dir_q     <= DIR_RST;
      afc_q     <= AFC_RST;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pm_q      <= '0;
      ps_q      <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_DO:      do_q          <= bus_wdata;
        REG_DO_SET:  do_q          <= do_q | bus_wdata;
        REG_DO_CLR:  do_q          <= do_q & ~bus_wdata;
        REG_DIR:     dir_q         <= bus_wdata;
        REG_AFC:     afc_q         <= bus_wdata;
        REG_RISE_EN: rise_en_q     <= bus_wdata;
        REG_FALL_EN: fall_en_q     <= bus_wdata;
        REG_PM_LO:   pm_q[31:0]    <= bus_wdata;
        REG_PM_HI:   pm_q[63:32]   <= bus_wdata;
        REG_PS_LO:   ps_q[31:0]    <= bus_wdata;
        REG_PS_HI:   ps_q[63:32]   <= bus_wdata;
        default: ;
      endcase
    end
  end

  // New events are OR'd in after the clear so a same-cycle event survives W1C
  assign w1c_mask = (wr_en && reg_idx == REG_IRQ_STAT) ? bus_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_stat_q <= '0;
    else        irq_stat_q <= (irq_stat_q & ~w1c_mask) | rise | fall;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_DO:       rd_mux = do_q;
      REG_DIR:      rd_mux = dir_q;
      REG_AFC:      rd_mux = afc_q;
      REG_PIN:      rd_mux = pin_sync;
      REG_RISE_EN:  rd_mux = rise_en_q;
      REG_FALL_EN:  rd_mux = fall_en_q;
      REG_IRQ_STAT: rd_mux = irq_stat_q;
      REG_PM_LO:    rd_mux = pm_q[31:0];
      REG_PM_HI:    rd_mux = pm_q[63:32];
      REG_PS_LO:    rd_mux = ps_q[31:0];
      REG_PS_HI:    rd_mux = ps_q[63:32];
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= bus_req;
      bus_rdata <= rd_en ? rd_mux : '0;
    end
  end

  assign GPIO_DI  = do_q;
  assign GPIO_DIR = dir_q;
  assign GPIO_AFC = afc_q;
  assign GPIO_PM  = pm_q;
  assign GPIO_PS  = ps_q;
  assign irq      = |irq_stat_q;

endmodule

// File: tb/tb_gpio_ctrl32.sv
// Directed self-checking bench for gpio_ctrl32: reset, set/clear, edge IRQs,
// AFC masking, W1C collision, back-to-back access and reset mid-request.
module tb_gpio_ctrl32;
  import gpio_pkg::*;

  localparam logic [31:0] DIR_RST_V = 32'h0000_FF00;
  localparam logic [31:0] AFC_RST_V = 32'h0000_0000;

  logic        clk, rst_n;
  logic        bus_req, bus_we;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [31:0] GPIO_DO, GPIO_DI, GPIO_DIR, GPIO_AFC;
  logic [63:0] GPIO_PM, GPIO_PS;
  logic        irq;

  int total = 0;
  int bad   = 0;

  gpio_ctrl32 #(
    .SYNC_STAGES (2),
    .DIR_RST     (DIR_RST_V),
    .AFC_RST     (AFC_RST_V)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .GPIO_DO   (GPIO_DO),
    .GPIO_DI   (GPIO_DI),
    .GPIO_DIR  (GPIO_DIR),
    .GPIO_AFC  (GPIO_AFC),
    .GPIO_PM   (GPIO_PM),
    .GPIO_PS   (GPIO_PS),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the following negedge, after the write edge.
  task automatic bus_write(input logic [3:0] idx, input logic [31:0] data);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = {idx, 2'b00}; bus_wdata = data;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [31:0] data, output logic ack);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = {idx, 2'b00};
    @(negedge clk);
    bus_req = 1'b0;
    data = bus_rdata;
    ack  = bus_ack;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a;
    rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; GPIO_DO = '0;
    wait_neg(3);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_in_reset: got %b expected 0", irq); end
    total++; if (bus_ack !== 1'b0) begin bad++; $display("[TB] FAIL ack_in_reset: got %b expected 0", bus_ack); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (GPIO_DI !== 32'h0) begin bad++; $display("[TB] FAIL rst_di: got %h expected 0", GPIO_DI); end
    total++; if (GPIO_DIR !== DIR_RST_V) begin bad++; $display("[TB] FAIL rst_dir: got %h expected %h", GPIO_DIR, DIR_RST_V); end
    total++; if (GPIO_AFC !== AFC_RST_V) begin bad++; $display("[TB] FAIL rst_afc: got %h expected %h", GPIO_AFC, AFC_RST_V); end
    total++; if (GPIO_PM !== 64'h0 || GPIO_PS !== 64'h0) begin bad++; $display("[TB] FAIL rst_pm_ps: got %h/%h expected 0/0", GPIO_PM, GPIO_PS); end
    total++; if (irq !== 1'b0 || bus_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_irq_rdata: got %b/%h expected 0/0", irq, bus_rdata); end
    bus_read(REG_DO, d, a);
    total++; if (a !== 1'b1) begin bad++; $display("[TB] FAIL rst_read_ack: got %b expected 1", a); end
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL rst_read_do: got %h expected 0", d); end
    @(negedge clk);
    total++; if (bus_ack !== 1'b0) begin bad++; $display("[TB] FAIL ack_one_cycle: got %b expected 0", bus_ack); end
    bus_read(REG_DIR, d, a);
    total++; if (d !== DIR_RST_V) begin bad++; $display("[TB] FAIL rst_read_dir: got %h expected %h", d, DIR_RST_V); end
  endtask

  task automatic test_set_clear();
    logic [31:0] d; logic a;
    bus_write(REG_DO, 32'h0000_00F0);
    total++; if (GPIO_DI !== 32'h0000_00F0) begin bad++; $display("[TB] FAIL do_write_visible: got %h expected 000000f0", GPIO_DI); end
    bus_write(REG_DO_SET, 32'h0000_000F);
    total++; if (GPIO_DI !== 32'h0000_00FF) begin bad++; $display("[TB] FAIL do_set: got %h expected 000000ff", GPIO_DI); end
    bus_write(REG_DO_CLR, 32'h0000_0030);
    total++; if (GPIO_DI !== 32'h0000_00CF) begin bad++; $display("[TB] FAIL do_clr: got %h expected 000000cf", GPIO_DI); end
    bus_write(4'hF, 32'hFFFF_FFFF);
    total++; if (GPIO_DI !== 32'h0000_00CF) begin bad++; $display("[TB] FAIL unmapped_write: got %h expected 000000cf", GPIO_DI); end
    bus_read(REG_DO, d, a);
    total++; if (d !== 32'h0000_00CF || a !== 1'b1) begin bad++; $display("[TB] FAIL read_do: got %h ack %b expected 000000cf ack 1", d, a); end
    bus_read(REG_DO_SET, d, a);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL read_do_set: got %h expected 0", d); end
    bus_read(REG_DO_CLR, d, a);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL read_do_clr: got %h expected 0", d); end
    bus_read(4'hD, d, a);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL read_unmapped: got %h expected 0", d); end
  endtask

  task automatic test_rise();
    logic [31:0] d; logic a;
    bus_write(REG_RISE_EN, 32'h1);
    bus_write(REG_AFC, 32'h0);
    GPIO_DO = 32'h1;
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rise_lat_n: got %b expected 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rise_lat_n1: got %b expected 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL rise_lat_n2: got %b expected 1", irq); end
    bus_read(REG_IRQ_STAT, d, a);
    total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL rise_stat: got %h expected 00000001", d); end
    bus_read(REG_PIN, d, a);
    total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL pin_read: got %h expected 00000001", d); end
    bus_write(REG_IRQ_STAT, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rise_w1c: got %b expected 0", irq); end
  endtask

  task automatic test_afc_mask();
    logic [31:0] d; logic a;
    bus_write(REG_FALL_EN, 32'h8);
    bus_write(REG_AFC, 32'h8);
    total++; if (GPIO_AFC !== 32'h8) begin bad++; $display("[TB] FAIL afc_out: got %h expected 00000008", GPIO_AFC); end
    GPIO_DO = 32'h9; wait_neg(4);
    GPIO_DO = 32'h1; wait_neg(4);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL afc_masked_irq: got %b expected 0", irq); end
    bus_read(REG_IRQ_STAT, d, a);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL afc_masked_stat: got %h expected 0", d); end
    bus_write(REG_AFC, 32'h0);
    GPIO_DO = 32'h9; wait_neg(4);
    GPIO_DO = 32'h1; wait_neg(4);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL fall_irq: got %b expected 1", irq); end
    bus_read(REG_IRQ_STAT, d, a);
    total++; if (d !== 32'h8) begin bad++; $display("[TB] FAIL fall_stat: got %h expected 00000008", d); end
    bus_write(REG_FALL_EN, 32'h0);
    bus_read(REG_IRQ_STAT, d, a);
    total++; if (d !== 32'h8) begin bad++; $display("[TB] FAIL en_clear_keeps: got %h expected 00000008", d); end
    bus_write(REG_IRQ_STAT, 32'h8);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL fall_w1c: got %b expected 0", irq); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d; logic a;
    bus_write(REG_RISE_EN, 32'h20);
    GPIO_DO = 32'h21;
    wait_neg(2);
    bus_write(REG_IRQ_STAT, 32'h20);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL collision_irq: got %b expected 1", irq); end
    bus_read(REG_IRQ_STAT, d, a);
    total++; if (d !== 32'h20) begin bad++; $display("[TB] FAIL collision_stat: got %h expected 00000020", d); end
    bus_write(REG_IRQ_STAT, 32'h20);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL collision_clear: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic a;
    logic [31:0] pm_pat, ps_pat;
    pm_pat = {16{PULL_DOWN}};
    ps_pat = {16{DRIVE_4MA}};
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = {REG_PM_LO, 2'b00}; bus_wdata = pm_pat;
    @(negedge clk);
    total++; if (bus_ack !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ack_w1: got %b expected 1", bus_ack); end
    bus_addr = {REG_PS_HI, 2'b00}; bus_wdata = ps_pat;
    @(negedge clk);
    total++; if (bus_ack !== 1'b1 || bus_rdata !== 32'h0) begin bad++; $display("[TB] FAIL b2b_ack_w2: got %b/%h expected 1/0", bus_ack, bus_rdata); end
    bus_we = 1'b0; bus_addr = {REG_PM_LO, 2'b00}; bus_wdata = '0;
    @(negedge clk);
    total++; if (bus_ack !== 1'b1 || bus_rdata !== 32'hAAAA_AAAA) begin bad++; $display("[TB] FAIL b2b_read_pm: got %b/%h expected 1/aaaaaaaa", bus_ack, bus_rdata); end
    bus_addr = {REG_PS_HI, 2'b00};
    @(negedge clk);
    total++; if (bus_ack !== 1'b1 || bus_rdata !== 32'h5555_5555) begin bad++; $display("[TB] FAIL b2b_read_ps: got %b/%h expected 1/55555555", bus_ack, bus_rdata); end
    bus_req = 1'b0;
    @(negedge clk);
    total++; if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin bad++; $display("[TB] FAIL b2b_idle: got %b/%h expected 0/0", bus_ack, bus_rdata); end
    total++; if (GPIO_PM[31:0] !== 32'hAAAA_AAAA || GPIO_PS[63:32] !== 32'h5555_5555) begin bad++; $display("[TB] FAIL pm_ps_ports: got %h/%h expected aaaaaaaa/55555555", GPIO_PM[31:0], GPIO_PS[63:32]); end

    bus_req = 1'b1; bus_we = 1'b1; bus_addr = {REG_PM_HI, 2'b00}; bus_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_drops_ack: got %b expected 0", bus_ack); end
    bus_req = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    wait_neg(2);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (GPIO_PM !== 64'h0 || GPIO_PS !== 64'h0) begin bad++; $display("[TB] FAIL reset_pm_ps: got %h/%h expected 0/0", GPIO_PM, GPIO_PS); end
    total++; if (GPIO_DI !== 32'h0 || GPIO_DIR !== DIR_RST_V) begin bad++; $display("[TB] FAIL reset_di_dir: got %h/%h expected 0/%h", GPIO_DI, GPIO_DIR, DIR_RST_V); end
    total++; if (irq !== 1'b0 || bus_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq_ack: got %b/%b expected 0/0", irq, bus_ack); end
    bus_read(REG_PS_HI, d, a);
    total++; if (d !== 32'h0 || a !== 1'b1) begin bad++; $display("[TB] FAIL reset_read_ps: got %h ack %b expected 0 ack 1", d, a); end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_rise();
    test_afc_mask();
    test_w1c_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl32.md
Name: gpio_ctrl32

Overview:
Register-mapped 32-bit GPIO controller that sits directly upstream of the pad alternate-function mux (AFIO32).
- Drives the mux control vectors: GPIO_DI, GPIO_DIR, GPIO_AFC, GPIO_PM and GPIO_PS.
- Consumes the pad readback GPIO_DO through a synchroniser.
- Detects per-pin rising and falling edges and raises a level interrupt.
- Accessed by the CPU over the simple single-cycle-ack peripheral bus.

Parameters:
SYNC_STAGES, 2, synchroniser depth on GPIO_DO (legal 2..4)
DIR_RST, 32'h0, reset value of the DIR register (0 = input)
AFC_RST, 32'h0, reset value of the AFC register (0 = GPIO owns the pin)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bus_req  in  1  access request, one-cycle pulse
bus_we  in  1  1 = write, 0 = read
bus_addr  in  6  byte address; [1:0] ignored
bus_wdata  in  32  write data
bus_rdata  out  32  read data, valid while bus_ack = 1
bus_ack  out  1  completion pulse, one cycle after bus_req
GPIO_DO  in  32  pad readback from AFIO32 (asynchronous to clk)
GPIO_DI  out  32  output data to AFIO32 (DO register)
GPIO_DIR  out  32  direction to AFIO32 (1 = output)
GPIO_AFC  out  32  alternate-function select (1 = AF owns the pin)
GPIO_PM  out  64  pull mode, 2 bits per pin
GPIO_PS  out  64  pad strength, 2 bits per pin
irq  out  1  level interrupt, OR of IRQ_STAT

Behaviour:
- Reset: asynchronous on rst_n low.
  - All registers, synchroniser flops, bus_rdata and bus_ack reset to 0.
  - DIR resets to DIR_RST; AFC resets to AFC_RST.
  - irq = 0 during and immediately after reset.
- Register map (word offsets; unmapped reads return 0, unmapped writes are ignored):
  - 0x00 DO: RW.
  - 0x04 DO_SET: WO; DO |= wdata.
  - 0x08 DO_CLR: WO; DO &= ~wdata.
  - 0x0C DIR: RW.
  - 0x10 AFC: RW.
  - 0x14 PIN: RO; synchronised GPIO_DO.
  - 0x18 RISE_EN: RW.
  - 0x1C FALL_EN: RW.
  - 0x20 IRQ_STAT: read; write-1-to-clear.
  - 0x24 PM_LO, 0x28 PM_HI, 0x2C PS_LO, 0x30 PS_HI: RW.
  - Reads of DO_SET and DO_CLR return 0.
- Bus protocol:
  - Write takes effect at the clk edge that samples bus_req.
  - bus_ack pulses high exactly one cycle later, for one cycle.
  - Reads are registered: bus_rdata holds the register value sampled at the bus_req edge and is valid with bus_ack. Otherwise bus_rdata = 0.
  - Back-to-back requests (bus_req high every cycle) are legal; one ack per request.
- Outputs: GPIO_DI, GPIO_DIR, GPIO_AFC, GPIO_PM and GPIO_PS are direct register outputs. A write is visible on the port the cycle after the write edge.
- Synchroniser and edge detection:
  - GPIO_DO passes through SYNC_STAGES flops (sync) followed by one history flop (prev).
  - rise = sync & ~prev & RISE_EN & ~AFC.
  - fall = ~sync & prev & FALL_EN & ~AFC.
- Latency with SYNC_STAGES = 2: a pin edge stable before clk edge N sets IRQ_STAT at edge N+2. PIN reflects the new value after edge N+1.
- IRQ_STAT update: IRQ_STAT <= (IRQ_STAT & ~w1c_mask) | rise | fall.
  - If a new event and a W1C hit the same bit in the same cycle, the set wins.
- Enable changes: clearing RISE_EN or FALL_EN does not clear pending IRQ_STAT bits.
- irq is the combinational OR of IRQ_STAT. No irq glitches occur because IRQ_STAT is registered.
- Reset mid-access: any in-flight ack is dropped; no partial write.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset localparams;
  - the register-field width constant (32);
  - the PM/PS 2-bit encoding constants.
- One sub-module: gpio_sync_edge.
  - Contains the SYNC_STAGES synchroniser, the prev flop and the rise/fall detect.
  - Parameterised on width and depth.
  - Instantiated once at 32 bits.

Test Plan:
- Reset values: hold rst_n low, then release → all outputs 0 except GPIO_DIR = DIR_RST and GPIO_AFC = AFC_RST; read 0x00 returns 0 with bus_ack one cycle after bus_req.
- Set/clear: write DO = 0x0000_00F0, DO_SET 0x0F, DO_CLR 0x30 → GPIO_DI = 0x0000_00CF; read DO returns 0xCF; read DO_SET returns 0.
- Rising edge: RISE_EN = 0x1, AFC = 0; drive GPIO_DO[0] 0→1 before edge N → IRQ_STAT = 0x1 and irq = 1 after edge N+2; W1C 0x1 → irq = 0.
- AFC masking: FALL_EN = 0x8, AFC = 0x8; GPIO_DO[3] 1→0 → IRQ_STAT stays 0. Set AFC = 0 and repeat → IRQ_STAT = 0x8.
- W1C collision: a rising event on bit 5 lands on the same edge as a W1C of 0x20 → IRQ_STAT[5] = 1 and irq stays 1.
- Back-to-back and async reset: write PM_LO = 0xAAAA_AAAA, PS_HI = 0x5555_5555, read both on consecutive cycles → GPIO_PM[31:0] = 0xAAAA_AAAA, GPIO_PS[63:32] = 0x5555_5555, with two acks. Then assert rst_n mid-request → no ack, and all of these registers return to 0.
